// File: rtl/alu_psr_writeback.sv
// rtl/alu_psr_writeback.sv - ALU result writeback slot, PSR flag merge and branch condition evaluation
module alu_psr_writeback #(
  parameter int DATA_LENGTH   = 16,
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     I_rst_n,
  input  logic                     I_valid,
  output logic                     O_ready,
  input  logic [DATA_LENGTH-1:0]   I_s,
  input  logic [REG_ADDR_BITS-1:0] I_dest,
  input  logic                     I_wb_en,
  input  logic                     I_upd_cf,
  input  logic                     I_upd_lzn,
  input  logic [15:0]              I_alu_psr,
  input  logic                     I_psr_wr,
  input  logic [15:0]              I_psr_wdata,
  input  logic [3:0]               I_cond,
  output logic                     O_wb_valid,
  input  logic                     I_wb_ready,
  output logic [DATA_LENGTH-1:0]   O_wb_data,
  output logic [REG_ADDR_BITS-1:0] O_wb_dest,
  output logic [15:0]              O_psr,
  output logic                     O_flag_busy,
  output logic                     O_cond_true
);

  localparam logic [15:0] CF_MASK  = 16'h0021;
  localparam logic [15:0] LZN_MASK = 16'h00C4;

  logic        accept;
  logic        pending;
  logic        upd_cf_q;
  logic        upd_lzn_q;
  logic [15:0] merge_mask;
  logic [15:0] psr_merged;
  logic        flag_z;
  logic        flag_c;
  logic        flag_l;
  logic        flag_n;
  logic        flag_f;

  assign O_ready     = ~O_wb_valid | I_wb_ready;
  assign accept      = I_valid & O_ready;
  assign O_flag_busy = pending;

  // Single writeback slot; a new entry may replace one leaving in the same cycle.
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_wb_valid <= 1'b0;
      O_wb_data  <= '0;
      O_wb_dest  <= '0;
    end else if (accept && I_wb_en) begin
      O_wb_valid <= 1'b1;
      O_wb_data  <= I_s;
      O_wb_dest  <= I_dest;
    end else if (I_wb_ready) begin
      O_wb_valid <= 1'b0;
    end
  end

  // Flags trail the result by one clock, so the masks ride along for one edge.
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pending   <= 1'b0;
      upd_cf_q  <= 1'b0;
      upd_lzn_q <= 1'b0;
    end else begin
      pending <= accept & (I_upd_cf | I_upd_lzn);
      if (accept) begin
        upd_cf_q  <= I_upd_cf;
        upd_lzn_q <= I_upd_lzn;
      end
    end
  end

  always_comb begin
    merge_mask = (upd_cf_q ? CF_MASK : 16'h0000) | (upd_lzn_q ? LZN_MASK : 16'h0000);
    psr_merged = (O_psr & ~merge_mask) | (I_alu_psr & merge_mask);
  end

  // LPR is younger than any merging ALU op, so it overrides the merge.
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_psr <= 16'h0000;
    end else if (I_psr_wr) begin
      O_psr <= I_psr_wdata;
    end else if (pending) begin
      O_psr <= psr_merged;
    end
  end

  assign flag_c = O_psr[0];
  assign flag_l = O_psr[2];
  assign flag_f = O_psr[5];
  assign flag_z = O_psr[6];
  assign flag_n = O_psr[7];

  always_comb begin
    O_cond_true = 1'b0;
    case (I_cond)
      4'h0: O_cond_true = flag_z;
      4'h1: O_cond_true = ~flag_z;
      4'h2: O_cond_true = flag_c;
      4'h3: O_cond_true = ~flag_c;
      4'h4: O_cond_true = flag_l;
      4'h5: O_cond_true = ~flag_l;
      4'h6: O_cond_true = flag_n;
      4'h7: O_cond_true = ~flag_n;
      4'h8: O_cond_true = flag_f;
      4'h9: O_cond_true = ~flag_f;
      4'hA: O_cond_true = ~flag_z & ~flag_l;
      4'hB: O_cond_true = flag_z | flag_l;
      4'hC: O_cond_true = ~flag_z & ~flag_n;
      4'hD: O_cond_true = flag_z | flag_n;
      4'hE: O_cond_true = 1'b1;
      default: O_cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_psr_writeback.sv
// tb/tb_alu_psr_writeback.sv - randomized and directed bench for alu_psr_writeback against a behavioural model
module tb_alu_psr_writeback;

  logic        clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic        I_valid = 1'b0;
  logic        O_ready;
  logic [15:0] I_s = '0;
  logic [3:0]  I_dest = '0;
  logic        I_wb_en = 1'b0;
  logic        I_upd_cf = 1'b0;
  logic        I_upd_lzn = 1'b0;
  logic [15:0] I_alu_psr = '0;
  logic        I_psr_wr = 1'b0;
  logic [15:0] I_psr_wdata = '0;
  logic [3:0]  I_cond = '0;
  logic        O_wb_valid;
  logic        I_wb_ready = 1'b0;
  logic [15:0] O_wb_data;
  logic [3:0]  O_wb_dest;
  logic [15:0] O_psr;
  logic        O_flag_busy;
  logic        O_cond_true;

  int checks = 0;
  int errors = 0;

  alu_psr_writeback #(.DATA_LENGTH(16), .REG_ADDR_BITS(4)) dut (
    .clk(clk), .I_rst_n(I_rst_n), .I_valid(I_valid), .O_ready(O_ready),
    .I_s(I_s), .I_dest(I_dest), .I_wb_en(I_wb_en), .I_upd_cf(I_upd_cf),
    .I_upd_lzn(I_upd_lzn), .I_alu_psr(I_alu_psr), .I_psr_wr(I_psr_wr),
    .I_psr_wdata(I_psr_wdata), .I_cond(I_cond), .O_wb_valid(O_wb_valid),
    .I_wb_ready(I_wb_ready), .O_wb_data(O_wb_data), .O_wb_dest(O_wb_dest),
    .O_psr(O_psr), .O_flag_busy(O_flag_busy), .O_cond_true(O_cond_true)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a one-entry writeback slot plus a list of flag updates owed to the PSR.
  logic        m_slot_full;
  logic [15:0] m_slot_data;
  logic [3:0]  m_slot_dest;
  logic [15:0] m_psr;
  logic        m_owed;
  logic [15:0] m_owed_mask;
  wire         m_accept = I_valid && (!m_slot_full || I_wb_ready);

  function automatic logic cond_holds(input logic [3:0] c, input logic [15:0] p);
    logic z, cy, l, n, f;
    z = p[6]; cy = p[0]; l = p[2]; n = p[7]; f = p[5];
    case (c)
      4'd0: return z;        4'd1: return !z;
      4'd2: return cy;       4'd3: return !cy;
      4'd4: return l;        4'd5: return !l;
      4'd6: return n;        4'd7: return !n;
      4'd8: return f;        4'd9: return !f;
      4'd10: return !z && !l; 4'd11: return z || l;
      4'd12: return !z && !n; 4'd13: return z || n;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      m_slot_full <= 1'b0;
      m_slot_data <= '0;
      m_slot_dest <= '0;
      m_psr       <= '0;
      m_owed      <= 1'b0;
      m_owed_mask <= '0;
    end else begin
      if (m_accept && I_wb_en) begin
        m_slot_full <= 1'b1;
        m_slot_data <= I_s;
        m_slot_dest <= I_dest;
      end else if (I_wb_ready) begin
        m_slot_full <= 1'b0;
      end
      if (I_psr_wr)
        m_psr <= I_psr_wdata;
      else if (m_owed)
        m_psr <= (m_psr & ~m_owed_mask) | (I_alu_psr & m_owed_mask);
      m_owed      <= m_accept && (I_upd_cf || I_upd_lzn);
      m_owed_mask <= (I_upd_cf ? 16'h0021 : 16'h0000) | (I_upd_lzn ? 16'h00C4 : 16'h0000);
    end
  end

  always @(negedge clk) begin
    chk("ready", {31'd0, O_ready}, {31'd0, !m_slot_full || I_wb_ready});
    chk("wb_valid", {31'd0, O_wb_valid}, {31'd0, m_slot_full});
    if (m_slot_full) begin
      chk("wb_data", {16'd0, O_wb_data}, {16'd0, m_slot_data});
      chk("wb_dest", {28'd0, O_wb_dest}, {28'd0, m_slot_dest});
    end
    chk("psr", {16'd0, O_psr}, {16'd0, m_psr});
    chk("flag_busy", {31'd0, O_flag_busy}, {31'd0, m_owed});
    chk("cond_true", {31'd0, O_cond_true}, {31'd0, cond_holds(I_cond, m_psr)});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    I_valid = 0; I_wb_en = 0; I_upd_cf = 0; I_upd_lzn = 0; I_psr_wr = 0;
  endtask

  initial begin
    #2;
    chk("rst_wb_valid", {31'd0, O_wb_valid}, 32'd0);
    chk("rst_psr", {16'd0, O_psr}, 32'd0);
    chk("rst_ready", {31'd0, O_ready}, 32'd1);
    chk("rst_busy", {31'd0, O_flag_busy}, 32'd0);
    step(); step();
    I_rst_n = 1;

    // Simple writeback with the register file ready.
    I_valid = 1; I_s = 16'h1234; I_dest = 4'd3; I_wb_en = 1; I_wb_ready = 1;
    step();
    chk("t1_valid", {31'd0, O_wb_valid}, 32'd1);
    chk("t1_data", {16'd0, O_wb_data}, 32'h1234);
    chk("t1_dest", {28'd0, O_wb_dest}, 32'd3);
    idle_inputs();
    step();
    chk("t1_drain", {31'd0, O_wb_valid}, 32'd0);

    // Stall: held data until the register file takes it.
    I_wb_ready = 0; I_valid = 1; I_wb_en = 1; I_s = 16'h1234;
    step();
    I_s = 16'hBEEF; I_dest = 4'd9;
    #1;
    chk("t2_ready_low", {31'd0, O_ready}, 32'd0);
    step();
    chk("t2_held", {16'd0, O_wb_data}, 32'h1234);
    I_wb_ready = 1;
    step();
    chk("t2_new", {16'd0, O_wb_data}, 32'hBEEF);
    idle_inputs();
    step();

    // C/F-only update.
    I_valid = 1; I_upd_cf = 1;
    step();
    chk("t3_busy", {31'd0, O_flag_busy}, 32'd1);
    idle_inputs(); I_alu_psr = 16'h00E5;
    step();
    chk("t3_busy_clr", {31'd0, O_flag_busy}, 32'd0);
    chk("t3_psr", {16'd0, O_psr}, 32'h0021);

    // Compare op, then condition codes.
    I_valid = 1; I_upd_lzn = 1;
    step();
    idle_inputs(); I_alu_psr = 16'h0044;
    step();
    chk("t4_psr", {16'd0, O_psr}, 32'h0065);
    I_cond = 4'h0; #1; chk("t4_eq", {31'd0, O_cond_true}, 32'd1);
    I_cond = 4'hA; #1; chk("t4_lo", {31'd0, O_cond_true}, 32'd0);
    I_cond = 4'hB; #1; chk("t4_hs", {31'd0, O_cond_true}, 32'd1);
    I_cond = 4'hF; #1; chk("t4_never", {31'd0, O_cond_true}, 32'd0);

    // LPR on the merge edge wins on every bit.
    @(posedge clk); #1;
    I_valid = 1; I_upd_cf = 1; I_upd_lzn = 1;
    step();
    idle_inputs(); I_alu_psr = 16'hFFFF; I_psr_wr = 1; I_psr_wdata = 16'h0080;
    step();
    chk("t5_psr", {16'd0, O_psr}, 32'h0080);
    idle_inputs();

    // Asynchronous reset mid-stall with a merge pending.
    I_wb_ready = 0; I_valid = 1; I_wb_en = 1; I_upd_cf = 1; I_s = 16'h5A5A;
    step();
    chk("t6_pre_busy", {31'd0, O_flag_busy}, 32'd1);
    idle_inputs();
    #1 I_rst_n = 0;
    #1;
    chk("t6_wb_valid", {31'd0, O_wb_valid}, 32'd0);
    chk("t6_psr", {16'd0, O_psr}, 32'd0);
    chk("t6_busy", {31'd0, O_flag_busy}, 32'd0);
    step();
    I_rst_n = 1;

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      I_valid     = ($urandom_range(0, 9) < 6);
      I_s         = 16'($urandom);
      I_dest      = 4'($urandom);
      I_wb_en     = ($urandom_range(0, 3) != 0);
      I_upd_cf    = $urandom_range(0, 1) == 1;
      I_upd_lzn   = $urandom_range(0, 1) == 1;
      I_alu_psr   = 16'($urandom);
      I_psr_wr    = ($urandom_range(0, 9) == 0);
      I_psr_wdata = 16'($urandom);
      I_cond      = 4'($urandom);
      I_wb_ready  = ($urandom_range(0, 9) < 7);
      step();
    end

    idle_inputs();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_psr_writeback.md
Name: alu_psr_writeback

Overview:
- Stage directly downstream of the 16-bit ALU.
- Captures each ALU result and its destination register index, and presents them to the register file through a valid/ready writeback handshake.
- Owns the architectural PSR: the ALU flags arrive one clock after the result, and this block merges them into the PSR under per-instruction update masks.
- Evaluates the 4-bit branch condition codes against the PSR and flags when a flag merge is still pending, so the branch unit can stall.

Parameters:
- DATA_LENGTH, 16, datapath width.
- REG_ADDR_BITS, 4, register-file index width.

Ports:
- clk  in  1  clock, rising edge.
- I_rst_n  in  1  asynchronous active-low reset.
- I_valid  in  1  ALU result valid this cycle.
- O_ready  out  1  stage can accept a result.
- I_s  in  DATA_LENGTH  combinational ALU result.
- I_dest  in  REG_ADDR_BITS  destination register index.
- I_wb_en  in  1  result is written to the register file.
- I_upd_cf  in  1  instruction updates C (bit 0) and F (bit 5).
- I_upd_lzn  in  1  instruction updates L (bit 2), Z (bit 6) and N (bit 7).
- I_alu_psr  in  16  registered ALU flags; valid one cycle after the accept.
- I_psr_wr  in  1  direct PSR load (LPR).
- I_psr_wdata  in  16  PSR load value.
- I_cond  in  4  condition code to evaluate.
- O_wb_valid  out  1  writeback valid.
- I_wb_ready  in  1  register file accepts writeback.
- O_wb_data  out  DATA_LENGTH  writeback data.
- O_wb_dest  out  REG_ADDR_BITS  writeback index.
- O_psr  out  16  architectural PSR.
- O_flag_busy  out  1  flag merge pending; O_cond_true is stale.
- O_cond_true  out  1  I_cond holds on the current O_psr.

Behaviour:
- Reset: on I_rst_n low, asynchronously clear O_wb_valid, O_wb_data, O_wb_dest, O_psr, the pending-merge state and the latched masks. O_ready is 1 out of reset. Reset mid-operation discards both the held result and any pending merge.
- O_ready is combinational: equal to ~O_wb_valid | I_wb_ready. There is no bubble under continuous flow.
- Accept condition: I_valid & O_ready.
- On accept with I_wb_en=1:
  - O_wb_data is loaded with I_s and O_wb_dest with I_dest.
  - O_wb_valid is set next edge.
- On accept with I_wb_en=0: no writeback entry is created.
- O_wb_valid clears when I_wb_ready=1 and no new I_wb_en accept occurs in the same cycle.
- While O_wb_valid=1 and I_wb_ready=0, O_wb_data and O_wb_dest are held stable.
- Flag pipeline, 1-deep:
  - On any accept where I_upd_cf | I_upd_lzn, latch both masks and set pending, so the merge happens on the next edge.
  - On the edge after the accept, merge I_alu_psr into O_psr:
    - bits 0 and 5 take I_alu_psr when upd_cf=1;
    - bits 2, 6 and 7 take I_alu_psr when upd_lzn=1;
    - all other bits are unchanged.
  - Pending clears on the merge edge. O_flag_busy equals pending.
  - Back-to-back accepts merge on consecutive edges. A new pending may be set on the same edge that the previous merge completes.
  - The merge proceeds regardless of writeback stall.
- PSR load:
  - I_psr_wr=1 loads the whole O_psr from I_psr_wdata next edge.
  - If a merge completes on the same edge, I_psr_wr wins on all bits, because LPR is the younger instruction.
  - The asserting pending flag is unaffected.
- O_psr bits 1, 3, 4 and 8–15 change only via I_psr_wr.
- Condition evaluation (combinational from O_psr, with Z=bit 6, C=bit 0, L=bit 2, N=bit 7, F=bit 5):
  - 0 EQ: Z=1; 1 NE: Z=0.
  - 2 CS: C=1; 3 CC: C=0.
  - 4 HI: L=1; 5 LS: L=0.
  - 6 GT: N=1; 7 LE: N=0.
  - 8 FS: F=1; 9 FC: F=0.
  - A LO: Z=0 & L=0; B HS: Z=1 | L=1.
  - C LT: Z=0 & N=0; D GE: Z=1 | N=1.
  - E: always 1; F: always 0.
- Latency:
  - Accept to O_wb_valid: 1 cycle.
  - Accept to updated O_psr and O_cond_true: 2 cycles.

Test Plan:
- Reset, then I_valid=1, I_s=16'h1234, I_dest=3, I_wb_en=1, I_wb_ready=1 -> next cycle O_wb_valid=1, O_wb_data=16'h1234, O_wb_dest=3; cycle after, O_wb_valid=0.
- Hold I_wb_ready=0 after an accept, then I_valid=1 with 16'hBEEF -> O_ready=0, data held at 16'h1234; raise I_wb_ready -> 16'hBEEF appears the next cycle.
- Accept with I_upd_cf=1, I_upd_lzn=0, and I_alu_psr=16'h00E5 the following cycle -> O_flag_busy=1 for one cycle; O_psr=16'h0021, bits 2, 6 and 7 untouched.
- Compare op with I_upd_lzn=1 and I_alu_psr=16'h0044 -> O_psr[6]=1 and [2]=1; with I_cond=0 O_cond_true=1, I_cond=A -> 0, I_cond=B -> 1, I_cond=F -> 0.
- Flag merge and I_psr_wr=1 with I_psr_wdata=16'h0080 on the same edge -> O_psr=16'h0080 exactly.
- Assert I_rst_n=0 mid-stall with pending=1 -> O_wb_valid=0, O_psr=0 and O_flag_busy=0 immediately, without waiting for clk.
